// File: rtl/tug_key_conditioner_pkg.sv
// tug_pkg: shared key FSM state encoding and default timing constants for the key conditioner.
package tug_pkg;
    typedef enum logic [1:0] {REL, PRESS_CHK, PRS, REL_CHK} key_state_t;
    localparam int TUG_DEBOUNCE_CYCLES = 16;
    localparam int TUG_SYNC_STAGES     = 2;
endpackage

// File: rtl/tug_key_conditioner_if.sv
// tug_key_conditioner_if: raw key pins and enable in, move pulses and held levels out.
interface tug_key_conditioner_if;
    logic key_l_n;
    logic key_r_n;
    logic enable;
    logic L;
    logic R;
    logic l_held;
    logic r_held;
    modport master (output key_l_n, key_r_n, enable, input L, R, l_held, r_held);
    modport slave  (input key_l_n, key_r_n, enable, output L, R, l_held, r_held);
endinterface

// File: rtl/tug_key_conditioner_key_debounce.sv
// key_debounce: synchronizer, debounce FSM and one-shot press pulse for a single active-low key.
module key_debounce
    import tug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = TUG_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = TUG_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    input  logic enable,
    output logic pulse,
    output logic held
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    key_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   pulse_q, held_q;
    logic                   s;

    assign s     = ~sync_q[SYNC_STAGES-1];
    assign pulse = pulse_q;
    assign held  = held_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            REL:       if (s) begin state_d = PRESS_CHK; cnt_d = CW'(1); end
            PRESS_CHK: if (!s) begin state_d = REL; cnt_d = '0; end
                       else if (cnt_q == DMAX) begin state_d = PRS; cnt_d = '0; end
                       else cnt_d = cnt_q + CW'(1);
            PRS:       if (!s) begin state_d = REL_CHK; cnt_d = CW'(1); end
            REL_CHK:   if (s) begin state_d = PRS; cnt_d = '0; end
                       else if (cnt_q == DMAX) begin state_d = REL; cnt_d = '0; end
                       else cnt_d = cnt_q + CW'(1);
            default:   begin state_d = REL; cnt_d = '0; end
        endcase
    end

    // Synchronizer resets to all-ones so a reset looks like a released key.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '1;
            state_q <= REL;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], key_n};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= enable && state_q == PRESS_CHK && state_d == PRS;
            held_q  <= state_d == PRS || state_d == REL_CHK;
        end
    end
endmodule

// File: rtl/tug_key_conditioner.sv
// tug_key_conditioner: two independent debounced key paths producing L/R move pulses.
module tug_key_conditioner
    import tug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = TUG_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = TUG_SYNC_STAGES
) (
    input logic                  clk,
    input logic                  reset,
    tug_key_conditioner_if.slave bus
);
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_left (
        .clk    (clk),
        .reset  (reset),
        .key_n  (bus.key_l_n),
        .enable (bus.enable),
        .pulse  (bus.L),
        .held   (bus.l_held)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_right (
        .clk    (clk),
        .reset  (reset),
        .key_n  (bus.key_r_n),
        .enable (bus.enable),
        .pulse  (bus.R),
        .held   (bus.r_held)
    );
endmodule

// File: tb/tb_tug_key_conditioner.sv
// tb_tug_key_conditioner: directed checks of press/release latency, bounce, gating and reset.
module tb_tug_key_conditioner;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   passed = 0;
    int   l_cnt = 0;
    int   r_cnt = 0;
    int   l0, r0;

    tug_key_conditioner_if bus ();

    tug_key_conditioner #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        l_cnt <= l_cnt + int'(bus.L === 1'b1);
        r_cnt <= r_cnt + int'(bus.R === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b0;
        bus.key_l_n = 1'b1;
        bus.key_r_n = 1'b1;
        bus.enable = 1'b1;
        tick(3);
        chk("rst_L", 32'(bus.L), 0);
        chk("rst_R", 32'(bus.R), 0);
        chk("rst_lheld", 32'(bus.l_held), 0);
        chk("rst_rheld", 32'(bus.r_held), 0);
        reset = 1'b1;
        tick(3);
        // clean left press: edge N is the first tick after driving low
        l0 = l_cnt;
        bus.key_l_n = 1'b0;
        tick(6);
        chk("press_L_n5", 32'(bus.L), 0);
        chk("press_held_n5", 32'(bus.l_held), 0);
        tick(1);
        chk("press_L_n6", 32'(bus.L), 1);
        chk("press_held_n6", 32'(bus.l_held), 1);
        chk("press_R_n6", 32'(bus.R), 0);
        tick(1);
        chk("press_L_n7", 32'(bus.L), 0);
        tick(12);
        chk("press_one_pulse", 32'(l_cnt), 32'(l0 + 1));
        chk("press_held_late", 32'(bus.l_held), 1);
        // asynchronous reset mid-hold, key still held through release
        reset = 1'b0;
        #1;
        chk("mid_rst_L", 32'(bus.L), 0);
        chk("mid_rst_R", 32'(bus.R), 0);
        chk("mid_rst_lheld", 32'(bus.l_held), 0);
        chk("mid_rst_rheld", 32'(bus.r_held), 0);
        reset = 1'b1;
        tick(6);
        chk("repress_L_n5", 32'(bus.L), 0);
        tick(1);
        chk("repress_L_n6", 32'(bus.L), 1);
        chk("repress_held_n6", 32'(bus.l_held), 1);
        tick(1);
        // release: held falls 6 edges after the release is sampled
        l0 = l_cnt;
        bus.key_l_n = 1'b1;
        tick(6);
        chk("rel_held_m5", 32'(bus.l_held), 1);
        tick(1);
        chk("rel_held_m6", 32'(bus.l_held), 0);
        chk("rel_L_m6", 32'(bus.L), 0);
        tick(4);
        chk("rel_no_pulse", 32'(l_cnt), 32'(l0));
        // bounce on right key: 3 low / 1 high three times, then hold low
        r0 = r_cnt;
        repeat (3) begin
            bus.key_r_n = 1'b0;
            tick(3);
            bus.key_r_n = 1'b1;
            tick(1);
        end
        bus.key_r_n = 1'b0;
        tick(6);
        chk("bounce_R_n5", 32'(bus.R), 0);
        chk("bounce_cnt_n5", 32'(r_cnt), 32'(r0));
        chk("bounce_rheld_n5", 32'(bus.r_held), 0);
        tick(1);
        chk("bounce_R_n6", 32'(bus.R), 1);
        tick(1);
        chk("bounce_R_n7", 32'(bus.R), 0);
        tick(10);
        chk("bounce_one_pulse", 32'(r_cnt), 32'(r0 + 1));
        bus.key_r_n = 1'b1;
        tick(10);
        chk("bounce_rel_rheld", 32'(bus.r_held), 0);
        // simultaneous press
        l0 = l_cnt;
        r0 = r_cnt;
        bus.key_l_n = 1'b0;
        bus.key_r_n = 1'b0;
        tick(7);
        chk("sim_L", 32'(bus.L), 1);
        chk("sim_R", 32'(bus.R), 1);
        tick(1);
        chk("sim_L_off", 32'(bus.L), 0);
        chk("sim_R_off", 32'(bus.R), 0);
        tick(10);
        chk("sim_L_once", 32'(l_cnt), 32'(l0 + 1));
        chk("sim_R_once", 32'(r_cnt), 32'(r0 + 1));
        bus.key_l_n = 1'b1;
        bus.key_r_n = 1'b1;
        tick(10);
        // enable gating: press while disabled, enable while held
        l0 = l_cnt;
        bus.enable = 1'b0;
        bus.key_l_n = 1'b0;
        tick(10);
        chk("gate_held", 32'(bus.l_held), 1);
        bus.enable = 1'b1;
        tick(10);
        chk("gate_no_pulse", 32'(l_cnt), 32'(l0));
        bus.key_l_n = 1'b1;
        tick(10);
        chk("gate_released", 32'(bus.l_held), 0);
        bus.key_l_n = 1'b0;
        tick(7);
        chk("gate_repress_L", 32'(bus.L), 1);
        tick(10);
        chk("gate_one_pulse", 32'(l_cnt), 32'(l0 + 1));
        bus.key_l_n = 1'b1;
        tick(10);
        // 3-cycle glitch is rejected
        l0 = l_cnt;
        bus.key_l_n = 1'b0;
        tick(3);
        bus.key_l_n = 1'b1;
        tick(10);
        chk("glitch_no_pulse", 32'(l_cnt), 32'(l0));
        chk("glitch_held", 32'(bus.l_held), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
